// File: rtl/gf180mcu_fd_sc_mcu7t5v0__clkdivgate_func.sv
// Glitch-free programmable clock divider/gate. Z is a registered 50%-duty clock
// of ratio 2*(code+1); stopping always completes the current low phase at full length.
module gf180mcu_fd_sc_mcu7t5v0__clkdivgate_func #(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic [WIDTH-1:0] DIV,
  input  logic             LOAD,
  output logic             Z,
  output logic             ACK,
  output logic             BUSY,
  inout  wire              VDD,
  inout  wire              VSS
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_STOPPING
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_div_q, w_div_q_nxt;
  logic [WIDTH-1:0] r_div_p, w_div_p_nxt;
  logic             r_z, w_z_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_ack;
  logic             w_tc;
  logic             w_to_idle;
  logic             w_apply;
  wire              w_unused_pwr;

  assign w_unused_pwr = VDD ^ VSS;

  assign w_tc = (r_state != S_IDLE) && (r_cnt == r_div_q);

  // NOTE: every signal gets its hold value first so no path leaves it unassigned (no latches).
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_z_nxt     = r_z;
    w_div_q_nxt = r_div_q;
    w_div_p_nxt = r_div_p;
    w_busy_nxt  = r_busy;
    w_to_idle   = 1'b0;
    w_apply     = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        w_z_nxt   = 1'b0;
        if (EN) w_state_nxt = S_RUN;
      end
      S_RUN, S_STOPPING: begin
        // Leaving only from a completed low phase keeps the last pulse full length.
        w_to_idle = (r_state == S_STOPPING) && !EN && w_tc && !r_z;
        if (r_state == S_RUN && !EN)          w_state_nxt = S_STOPPING;
        else if (r_state == S_STOPPING && EN) w_state_nxt = S_RUN;
        else if (w_to_idle)                   w_state_nxt = S_IDLE;

        if (w_tc) begin
          w_cnt_nxt = '0;
          if (!w_to_idle) w_z_nxt = !r_z;
        end else begin
          w_cnt_nxt = r_cnt + WIDTH'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // New codes only land at a falling edge of Z (or when stopped) so phases never shrink mid-way.
    w_apply = (w_tc && r_z) || w_to_idle;
    if (r_state == S_IDLE || w_apply) begin
      if (LOAD)        w_div_q_nxt = DIV;
      else if (r_busy) w_div_q_nxt = r_div_p;
      w_busy_nxt = 1'b0;
    end else if (LOAD) begin
      w_div_p_nxt = DIV;
      w_busy_nxt  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_z     <= 1'b0;
      r_div_q <= '0;
      r_div_p <= '0;
      r_busy  <= 1'b0;
      r_ack   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_z     <= w_z_nxt;
      r_div_q <= w_div_q_nxt;
      r_div_p <= w_div_p_nxt;
      r_busy  <= w_busy_nxt;
      r_ack   <= (w_state_nxt != S_IDLE);
    end
  end

  assign Z    = r_z;
  assign ACK  = r_ack;
  assign BUSY = r_busy;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__clkdivgate_func.sv
// Self-checking bench for the clock divider/gate: directed scenario tasks plus a
// randomized run against a phase-length reference model.
module tb_gf180mcu_fd_sc_mcu7t5v0__clkdivgate_func;

  localparam int WIDTH = 4;

  logic             CLK = 1'b0;
  logic             RST = 1'b1;
  logic             EN = 1'b0;
  logic             LOAD = 1'b0;
  logic [WIDTH-1:0] DIV = '0;
  logic             Z, ACK, BUSY;
  wire              VDD, VSS;

  assign VDD = 1'b1;
  assign VSS = 1'b0;

  int checks = 0;
  int errors = 0;

  gf180mcu_fd_sc_mcu7t5v0__clkdivgate_func #(.WIDTH(WIDTH)) dut (
    .CLK (CLK),
    .RST (RST),
    .EN  (EN),
    .DIV (DIV),
    .LOAD(LOAD),
    .Z   (Z),
    .ACK (ACK),
    .BUSY(BUSY),
    .VDD (VDD),
    .VSS (VSS)
  );

  always #5 CLK = ~CLK;

  // Reference model: each phase of Z lasts (code+1) samples; m_done counts samples seen so far.
  int m_mode;  // 0 idle, 1 run, 2 stopping
  bit m_z, m_ack, m_pend_valid;
  int m_done, m_code, m_pend;

  task automatic model_step(input bit rst, input bit en, input bit load, input int div);
    bit last, z_old, to_idle, boundary;
    if (rst) begin
      m_mode = 0; m_z = 0; m_ack = 0; m_pend_valid = 0;
      m_done = 1; m_code = 0; m_pend = 0;
      return;
    end
    if (m_mode == 0) begin
      if (load) m_code = div;
      if (en) m_mode = 1;
      m_done = 1; m_z = 0; m_ack = en;
      return;
    end
    z_old    = m_z;
    last     = (m_done == m_code + 1);
    to_idle  = last && !z_old && (m_mode == 2) && !en;
    boundary = (last && z_old) || to_idle;
    if (m_mode == 1 && !en)      m_mode = 2;
    else if (m_mode == 2 && en)  m_mode = 1;
    else if (to_idle)            m_mode = 0;
    if (last) begin
      m_done = 1;
      if (!to_idle) m_z = !z_old;
    end else begin
      m_done = m_done + 1;
    end
    if (boundary) begin
      if (load)              m_code = div;
      else if (m_pend_valid) m_code = m_pend;
      m_pend_valid = 0;
    end else if (load) begin
      m_pend = div;
      m_pend_valid = 1;
    end
    m_ack = (m_mode != 0);
  endtask

  task automatic tick();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic do_reset();
    RST = 1; EN = 0; LOAD = 0; DIV = '0;
    tick();
    RST = 0;
  endtask

  task automatic wait_rise(input string name, input int budget);
    logic prev;
    bit   seen;
    prev = Z;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      tick();
      if (Z && !prev) seen = 1;
      prev = Z;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL %s: no Z rise within %0d cycles", name, budget);
    end
  endtask

  task automatic test_reset();
    RST = 1; EN = 1; LOAD = 1; DIV = 4'd7;
    tick();
    checks++; if (Z !== 1'b0)    begin errors++; $display("FAIL reset_z: got %b expected 0", Z); end
    checks++; if (ACK !== 1'b0)  begin errors++; $display("FAIL reset_ack: got %b expected 0", ACK); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", BUSY); end
    RST = 0; EN = 0; LOAD = 0;
    tick();
    checks++; if (ACK !== 1'b0)  begin errors++; $display("FAIL idle_ack: got %b expected 0", ACK); end
  endtask

  task automatic test_div2();
    do_reset();
    DIV = 4'd0; LOAD = 1; EN = 1;
    tick();
    checks++; if (ACK !== 1'b1)  begin errors++; $display("FAIL div2_ack: got %b expected 1", ACK); end
    checks++; if (Z !== 1'b0)    begin errors++; $display("FAIL div2_z0: got %b expected 0", Z); end
    checks++; if (BUSY !== 1'b0) begin errors++; $display("FAIL div2_busy: got %b expected 0", BUSY); end
    LOAD = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      checks++;
      if (Z !== logic'(k % 2 == 0)) begin
        errors++; $display("FAIL div2_z[%0d]: got %b expected %b", k, Z, (k % 2 == 0));
      end
    end
  endtask

  task automatic test_div6();
    do_reset();
    DIV = 4'd2; LOAD = 1; EN = 0;
    tick();
    LOAD = 0; EN = 1;
    tick();
    for (int k = 1; k <= 18; k++) begin
      tick();
      checks++;
      if (Z !== logic'((k / 3) % 2) || ACK !== 1'b1) begin
        errors++; $display("FAIL div6_z[%0d]: got z=%b ack=%b expected z=%0d ack=1", k, Z, ACK, (k / 3) % 2);
      end
    end
  endtask

  task automatic test_stop();
    logic z_exp [5];
    logic a_exp [5];
    z_exp = '{1, 0, 0, 0, 0};
    a_exp = '{1, 1, 1, 1, 0};
    wait_rise("stop_rise", 20);
    tick();
    EN = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      checks++;
      if (Z !== z_exp[k] || ACK !== a_exp[k]) begin
        errors++; $display("FAIL stop[%0d]: got z=%b ack=%b expected z=%b ack=%b", k, Z, ACK, z_exp[k], a_exp[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (Z !== 1'b0 || ACK !== 1'b0) begin
        errors++; $display("FAIL stop_idle[%0d]: got z=%b ack=%b expected 0/0", k, Z, ACK);
      end
    end
  endtask

  task automatic test_reload();
    logic prev;
    bit   seen;
    logic b_exp [4];
    logic z_exp [4];
    b_exp = '{1, 1, 1, 0};
    z_exp = '{0, 1, 1, 0};
    do_reset();
    DIV = 4'd1; LOAD = 1;
    tick();
    LOAD = 0; EN = 1;
    tick();
    prev = Z; seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (!Z && prev) seen = 1;
      prev = Z;
    end
    checks++;
    if (!seen) begin errors++; $display("FAIL reload_fall: no Z fall within 20 cycles"); end
    for (int k = 0; k < 4; k++) begin
      LOAD = (k < 2);
      DIV  = (k == 0) ? 4'd3 : 4'd0;
      tick();
      checks++;
      if (BUSY !== b_exp[k] || Z !== z_exp[k]) begin
        errors++; $display("FAIL reload[%0d]: got busy=%b z=%b expected busy=%b z=%b", k, BUSY, Z, b_exp[k], z_exp[k]);
      end
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (Z !== logic'(k % 2 == 0) || BUSY !== 1'b0) begin
        errors++; $display("FAIL reload_div2[%0d]: got z=%b busy=%b expected z=%b busy=0", k, Z, BUSY, (k % 2 == 0));
      end
    end
  endtask

  task automatic test_reenable();
    do_reset();
    DIV = 4'd2; LOAD = 1;
    tick();
    LOAD = 0; EN = 1;
    tick();
    wait_rise("reen_rise", 20);
    for (int j = 1; j <= 26; j++) begin
      if (j == 2) EN = 0;
      if (j == 3) EN = 1;
      tick();
      checks++;
      if (Z !== logic'((j % 6) < 3) || ACK !== 1'b1) begin
        errors++; $display("FAIL reenable[%0d]: got z=%b ack=%b expected z=%b ack=1", j, Z, ACK, ((j % 6) < 3));
      end
    end
  endtask

  task automatic test_rst_mid_run();
    wait_rise("rst_rise", 20);
    RST = 1; EN = 1; LOAD = 1; DIV = 4'd5;
    tick();
    checks++;
    if (Z !== 1'b0 || ACK !== 1'b0 || BUSY !== 1'b0) begin
      errors++; $display("FAIL rst_mid: got z=%b ack=%b busy=%b expected 0/0/0", Z, ACK, BUSY);
    end
    RST = 0; LOAD = 0;
    tick();
    checks++;
    if (ACK !== 1'b1 || Z !== 1'b0) begin
      errors++; $display("FAIL rst_restart: got ack=%b z=%b expected 1/0", ACK, Z);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (Z !== logic'(k % 2 == 0)) begin
        errors++; $display("FAIL rst_div2[%0d]: got %b expected %b", k, Z, (k % 2 == 0));
      end
    end
  endtask

  task automatic test_random();
    bit r_rst, r_en, r_load;
    int r_div;
    do_reset();
    model_step(1, 0, 0, 0);
    r_en = 0;
    for (int i = 0; i < 800; i++) begin
      r_rst  = ($urandom_range(0, 149) == 0);
      if ($urandom_range(0, 5) == 0) r_en = !r_en;
      r_load = ($urandom_range(0, 4) == 0);
      r_div  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      RST = r_rst; EN = r_en; LOAD = r_load; DIV = WIDTH'(r_div);
      model_step(r_rst, r_en, r_load, r_div);
      tick();
      checks++;
      if (Z !== m_z || ACK !== m_ack || BUSY !== m_pend_valid) begin
        errors++;
        $display("FAIL random[%0d]: got z=%b ack=%b busy=%b expected z=%b ack=%b busy=%b",
                 i, Z, ACK, BUSY, m_z, m_ack, m_pend_valid);
      end
    end
    RST = 0; LOAD = 0;
  endtask

  initial begin
    test_reset();
    test_div2();
    test_div6();
    test_stop();
    test_reload();
    test_reenable();
    test_rst_mid_run();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/gf180mcu_fd_sc_mcu7t5v0__clkdivgate_func.md
GF180MCU_FD_SC_MCU7T5V0__CLKDIVGATE_FUNC -- requirements
Module: gf180mcu_fd_sc_mcu7t5v0__clkdivgate_func

Purpose: glitch-free programmable divider/gate that produces the divided clock driving the downstream clock-inverter tree stage.

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, which is the width of the half-period divide code.
REQ-002 The block SHALL have port CLK, input, 1 bit: the single source clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RST, input, 1 bit: synchronous reset, active-high.
REQ-004 The block SHALL have port EN, input, 1 bit: level request to run the divided clock.
REQ-005 The block SHALL have port DIV, input, WIDTH bits: half-period length minus one, so the ratio is 2*(DIV+1).
REQ-006 The block SHALL have port LOAD, input, 1 bit: one-cycle strobe that captures DIV as the pending code.
REQ-007 The block SHALL have port Z, output, 1 bit: the divided clock, registered, feeding the clock-inverter stage.
REQ-008 The block SHALL have port ACK, output, 1 bit: high while the divider is in RUN or STOPPING.
REQ-009 The block SHALL have port BUSY, output, 1 bit: high while a loaded code is pending and not yet applied.
REQ-010 The block SHALL have ports VDD and VSS, inout, 1 bit each: power pins with no functional use.

Function
REQ-011 The block SHALL hold the internal state div_q (active code), div_p (pending code), CNT (WIDTH bits) and FSM state IDLE/RUN/STOPPING.
REQ-012 The terminal count (TC) SHALL be defined as CNT==div_q while the state is RUN or STOPPING.
REQ-013 In RUN or STOPPING, on TC the block SHALL set CNT to 0 and toggle Z; otherwise CNT increments by 1. CNT never exceeds div_q.
REQ-014 IDLE with EN=1 SHALL go to RUN next cycle with CNT=0 and Z=0. The first Z rise SHALL occur div_q+1 cycles after RUN entry.
REQ-015 RUN with EN=0 SHALL go to STOPPING, and counting SHALL continue unchanged.
REQ-016 STOPPING on TC with Z=1 SHALL toggle Z to 0 and remain in STOPPING, so the low phase completes at full length.
REQ-017 STOPPING on TC with Z=0 SHALL go to IDLE, hold Z=0 (no toggle) and set CNT=0. The block SHALL never emit a runt pulse.
REQ-018 STOPPING with EN=1 SHALL return to RUN without disturbing CNT or Z.
REQ-019 In IDLE, Z SHALL be 0 and CNT SHALL be 0.
REQ-020 ACK SHALL be registered: 1 from the cycle the state becomes RUN until the cycle it becomes IDLE.
REQ-021 LOAD in IDLE SHALL write DIV directly to div_q next cycle, with BUSY staying 0.
REQ-022 LOAD in RUN or STOPPING SHALL write DIV to div_p and set BUSY=1 next cycle.
REQ-023 div_p SHALL be applied to div_q only on a TC with Z=1 (the falling-edge boundary), or on entry to IDLE; BUSY SHALL clear in the same cycle.
REQ-024 LOAD while BUSY=1 SHALL overwrite div_p. Only the last value is applied.
REQ-025 LOAD in the same cycle as an apply boundary SHALL apply the current DIV input directly, with BUSY=0 afterwards.
REQ-026 A code change SHALL take effect starting with the next low phase; no phase SHALL be shorter than min(old, new)+1 cycles.
REQ-027 LOAD and EN SHALL be independent; simultaneous EN fall and LOAD SHALL both be honoured per the rules above.

Reset
REQ-028 While RST=1 at a CLK edge, the block SHALL set Z=0, ACK=0, BUSY=0, state=IDLE, CNT=0, div_q=0 and div_p=0.
REQ-029 RST SHALL override EN and LOAD in the same cycle.
REQ-030 RST asserted mid-RUN SHALL force Z=0 at that edge, with no stop sequence.
REQ-031 All outputs SHALL be known (not X) from the first reset edge.

Verification
REQ-032 Reset then DIV=0, LOAD, EN=1 at cycle 0 -> the bench SHALL check ACK=1 after edge 1, then Z=1,0,1,0... toggling every edge from edge 2 (divide by 2).
REQ-033 DIV=2 loaded in IDLE, EN=1 -> the bench SHALL check Z is high for 3 and low for 3 cycles repeatedly, with the first rise 3 cycles after RUN entry.
REQ-034 Running at DIV=2, drop EN mid-high-phase -> the bench SHALL check the high phase completes (3), the low phase is full (3), then IDLE, ACK=0, Z=0, and no pulse shorter than 3.
REQ-035 Running at DIV=1, LOAD DIV=3 then LOAD DIV=0 before the boundary -> the bench SHALL check BUSY=1 until the next falling edge of Z, then half-periods of 1 cycle and BUSY=0.
REQ-036 In STOPPING, reassert EN before TC -> the bench SHALL check ACK stays 1 and the Z period is unchanged.
REQ-037 RST=1 pulsed while Z=1 in RUN -> the bench SHALL check Z=0, ACK=0, BUSY=0 next cycle, and that a restart uses divide-by-2.
